float_sq_mul_arb: RTL and testbench

Round-robin arbiter sharing one `float_sq_mul` unit (computes `float_in_sq² × float_in_mul`) between `NUM_REQ` requesters, e.g. parallel inverse-square-root Newton iteration lanes. The block captures the winning requester's operands, pulses the unit's `start`, waits for its `ready`, and returns the result to the owning requester. It sits between the lane controllers and the single shared multiplier instance.

---
 rtl/float_sq_mul_arb_pkg.sv | 23 ++
 rtl/float_sq_mul_arb_if.sv | 36 +++
 rtl/float_sq_mul_arb_rr_pick.sv | 31 +++
 rtl/float_sq_mul_arb.sv | 168 ++++++++++++++++
 tb/tb_float_sq_mul_arb.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_sq_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsqm_arb_pkg
// Brief    : Shared types and constants for the float_sq_mul round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fsqm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fsqm_state_t;

    localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;

    function automatic int owner_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_sq_mul_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : float_sq_mul_arb_if
// Brief    : Requester-side and shared-unit-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface float_sq_mul_arb_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] sq_in;
    logic [32*NUM_REQ-1:0] mul_in;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           result;
    logic                  err;
    logic                  unit_start;
    logic [31:0]           unit_sq;
    logic [31:0]           unit_mul;
    logic [31:0]           unit_result;
    logic                  unit_ready;
    logic                  unit_flush;

    // Arbiter side
    modport slave (
        input  req, sq_in, mul_in, unit_result, unit_ready,
        output grant, done, result, err, unit_start, unit_sq, unit_mul, unit_flush
    );

    // Environment side (lanes plus shared unit)
    modport master (
        output req, sq_in, mul_in, unit_result, unit_ready,
        input  grant, done, result, err, unit_start, unit_sq, unit_mul, unit_flush
    );
endinterface
`default_nettype wire

// File: rtl/float_sq_mul_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first set request after i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fsqm_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);
    always_comb begin
        o_winner = '0;
        // Walk from farthest to nearest so the nearest set bit is written last.
        for (int i = NUM_REQ; i >= 1; i--) begin
            logic [IDX_W-1:0] w_idx;
            w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
            end
        end
        o_any = |i_req;
    end
endmodule
`default_nettype wire

// File: rtl/float_sq_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : float_sq_mul_arb
// Brief    : Round-robin sharing of one float_sq_mul unit among NUM_REQ lanes.
//            Optional WAIT timeout/abort enabled by macro FSQM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module float_sq_mul_arb
    import fsqm_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    float_sq_mul_arb_if.slave bus
);
    localparam int c_idx_w = owner_width(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_onehot_lsb = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("float_sq_mul_arb: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    fsqm_state_t          r_state;
    fsqm_state_t          w_state_next;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   w_winner;
    logic                 w_any_req;
    logic                 w_grant_load;
    logic                 w_start;
    logic                 w_finish;
    logic                 w_abort;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_start;
    logic [31:0]          r_result;
    logic [31:0]          r_unit_sq;
    logic [31:0]          r_unit_mul;
    logic [31:0]          w_sq_slice  [NUM_REQ];
    logic [31:0]          w_mul_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_sq_slice[g]  = bus.sq_in[32*g +: 32];
        assign w_mul_slice[g] = bus.mul_in[32*g +: 32];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = ISSUE;
                    w_grant_load = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = WAIT;
                w_start      = 1'b1;
            end
            WAIT: begin
                if (bus.unit_ready || w_abort) begin
                    w_state_next = DELIVER;
                    w_finish     = 1'b1;
                end
            end
            DELIVER: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // All strobes are registered so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_done     <= '0;
            r_start    <= 1'b0;
            r_result   <= '0;
            r_unit_sq  <= '0;
            r_unit_mul <= '0;
            r_owner    <= '0;
            r_ptr      <= c_idx_w'(NUM_REQ - 1);
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            r_start <= w_start;
            if (w_grant_load) begin
                r_grant    <= c_onehot_lsb << w_winner;
                r_owner    <= w_winner;
                r_unit_sq  <= w_sq_slice[w_winner];
                r_unit_mul <= w_mul_slice[w_winner];
            end
            if (w_finish) begin
                r_done   <= c_onehot_lsb << r_owner;
                r_result <= bus.unit_ready ? bus.unit_result : FLOAT_QNAN;
            end
            if (r_state == DELIVER) begin
                r_ptr <= r_owner;
            end
        end
    end

`ifdef FSQM_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_err;
    logic               r_flush;

    // A ready arriving on the expiry cycle takes priority over the abort.
    assign w_abort = (r_state == WAIT) && !bus.unit_ready &&
                     (r_wait_cnt == c_cnt_w'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_err   <= w_abort;
            r_flush <= w_abort;
            if (r_state != WAIT) begin
                r_wait_cnt <= '0;
            end else if (!w_abort) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.err        = r_err;
    assign bus.unit_flush = r_flush;
`else
    assign w_abort        = 1'b0;
    assign bus.err        = 1'b0;
    assign bus.unit_flush = 1'b0;
`endif

    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.unit_start = r_start;
    assign bus.unit_sq    = r_unit_sq;
    assign bus.unit_mul   = r_unit_mul;

endmodule
`default_nettype wire

// File: tb/tb_float_sq_mul_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_float_sq_mul_arb
// Brief    : Self-checking bench for float_sq_mul_arb with a 7-cycle unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_sq_mul_arb;
    import fsqm_arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int TIMEOUT  = 16;
    localparam int UNIT_LAT = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    float_sq_mul_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    float_sq_mul_arb #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] sq;
        logic [31:0] mul;
        logic [31:0] prod;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] sq, input logic [31:0] mul);
        logic [31:0] r;
        r = 32'hBAD0_0000;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sq == sq && vecs[i].mul == mul) r = vecs[i].prod;
        end
        return r;
    endfunction

    // Shared unit model: ready pulse UNIT_LAT cycles after start.
    logic        model_ready  = 1'b0;
    logic [31:0] model_result = 32'h0;
    logic        spur_ready   = 1'b0;
    logic        suppress     = 1'b0;
    int          ucnt         = 0;

    always @(negedge clk) begin
        if (rst) begin
            ucnt        <= 0;
            model_ready <= 1'b0;
        end else if (bus.unit_start) begin
            ucnt        <= UNIT_LAT;
            model_ready <= 1'b0;
        end else if (ucnt > 0) begin
            ucnt         <= ucnt - 1;
            model_ready  <= (ucnt == 1) && !suppress;
            model_result <= lookup(bus.unit_sq, bus.unit_mul);
        end else begin
            model_ready <= 1'b0;
        end
    end

    assign bus.unit_ready  = model_ready | spur_ready;
    assign bus.unit_result = spur_ready ? 32'hDEAD_BEEF : model_result;

    // Scoreboard: every done must match the oldest expected completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done != '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=%b expected none", bus.done);
            end else begin
                e = sb.pop_front();
                check("done_idx", 32'(bus.done), 32'(1 << e.idx));
                check("result", bus.result, e.res);
                check("err", 32'(bus.err), 32'(e.err));
                check("unit_flush", 32'(bus.unit_flush), 32'(e.err));
            end
        end
    end

    task automatic wait_grant(output int gidx, output int gcyc);
        gidx = -1;
        gcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                gcyc = cyc;
                for (int j = 0; j < NUM_REQ; j++) if (bus.grant[j]) gidx = j;
                break;
            end
        end
        if (gidx < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: got no grant expected grant within 40 cycles");
        end
    endtask

    // sel 0: unit_start, sel 1: any done
    task automatic wait_for(input int sel, input string name, output int ecyc);
        ecyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel == 0 && bus.unit_start) || (sel == 1 && bus.done != '0)) begin
                ecyc = cyc;
                break;
            end
        end
        if (ecyc < 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no event expected one within 40 cycles", name);
        end
    endtask

    task automatic set_operands(input int v);
        bus.sq_in[32*vecs[v].idx +: 32]  = vecs[v].sq;
        bus.mul_in[32*vecs[v].idx +: 32] = vecs[v].mul;
    endtask

    task automatic run_single(input int v);
        int t, gidx, gcyc, scyc, dcyc;
        @(negedge clk);
        set_operands(v);
        bus.req[vecs[v].idx] = 1'b1;
        t = cyc;
        sb.push_back('{vecs[v].idx, vecs[v].prod, 1'b0});
        wait_grant(gidx, gcyc);
        bus.req[vecs[v].idx] = 1'b0;
        check("grant_idx", gidx, vecs[v].idx);
        wait_for(0, "unit_start", scyc);
        wait_for(1, "done", dcyc);
        check("grant_latency", gcyc - t, 1);
        check("start_latency", scyc - t, 2);
        check("done_latency", dcyc - t, 10);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
        check({tag, "_unit_start"}, 32'(bus.unit_start), 32'h0);
        check({tag, "_result"}, bus.result, 32'h0);
        check({tag, "_unit_sq"}, bus.unit_sq, 32'h0);
        check({tag, "_unit_mul"}, bus.unit_mul, 32'h0);
        check({tag, "_err"}, 32'(bus.err), 32'h0);
        check({tag, "_unit_flush"}, 32'(bus.unit_flush), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int rr_vec [4];
        int gidx, gcyc, prev, ecyc;

        vecs[0] = '{2, 32'h4000_0000, 32'h3F00_0000, 32'h4000_0000}; //  2.0^2 *  0.5 =   2.0
        vecs[1] = '{0, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000}; //  1.0^2 *  3.0 =   3.0
        vecs[2] = '{1, 32'h4040_0000, 32'h4000_0000, 32'h4190_0000}; //  3.0^2 *  2.0 =  18.0
        vecs[3] = '{3, 32'h3F00_0000, 32'h4080_0000, 32'h3F80_0000}; //  0.5^2 *  4.0 =   1.0
        vecs[4] = '{1, 32'hC000_0000, 32'h3F80_0000, 32'h4080_0000}; // -2.0^2 *  1.0 =   4.0
        vecs[5] = '{3, 32'h40A0_0000, 32'hBF80_0000, 32'hC1C8_0000}; //  5.0^2 * -1.0 = -25.0
        rr_vec = '{1, 2, 0, 3};

        bus.req    = '0;
        bus.sq_in  = '0;
        bus.mul_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_single(v);

        // All four lanes requesting continuously out of reset
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) set_operands(rr_vec[j]);
        bus.req = 4'hF;
        for (int k = 0; k < 5; k++) sb.push_back('{k % 4, vecs[rr_vec[k % 4]].prod, 1'b0});
        @(negedge clk);
        rst  = 1'b0;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(gidx, gcyc);
            check("rr_order", gidx, k % 4);
            if (k > 0) check("rr_interval", gcyc - prev, 11);
            prev = gcyc;
            if (k == 4) bus.req = '0;
        end
        wait_for(1, "rr_last_done", ecyc);
        @(negedge clk);

        // Owner 1 just served, then 1 and 3 contend: 3 wins first
        run_single(4);
        @(negedge clk);
        set_operands(5);
        set_operands(4);
        bus.req = 4'b1010;
        sb.push_back('{3, vecs[5].prod, 1'b0});
        sb.push_back('{1, vecs[4].prod, 1'b0});
        wait_grant(gidx, gcyc);
        check("contend_first", gidx, 3);
        bus.req[3] = 1'b0;
        wait_grant(gidx, gcyc);
        check("contend_second", gidx, 1);
        bus.req[1] = 1'b0;
        wait_for(1, "contend_done", ecyc);
        @(negedge clk);

        // Reset asserted while waiting on the unit
        @(negedge clk);
        set_operands(0);
        bus.req[2] = 1'b1;
        wait_grant(gidx, gcyc);
        bus.req[2] = 1'b0;
        wait_for(0, "midrst_start", ecyc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_single(3);

        // Spurious ready while idle must not disturb anything
        @(negedge clk);
        spur_ready = 1'b1;
        repeat (2) @(negedge clk);
        spur_ready = 1'b0;
        @(negedge clk);
        check("spur_result", bus.result, vecs[3].prod);
        check("spur_done", 32'(bus.done), 32'h0);

`ifdef FSQM_ARB_TIMEOUT_EN
        begin : timeout_case
            int scyc, dcyc;
            suppress = 1'b1;
            @(negedge clk);
            set_operands(2);
            bus.req[1] = 1'b1;
            sb.push_back('{1, FLOAT_QNAN, 1'b1});
            wait_grant(gidx, gcyc);
            bus.req[1] = 1'b0;
            wait_for(0, "to_start", scyc);
            wait_for(1, "to_done", dcyc);
            check("timeout_latency", dcyc - scyc, 17);
            @(negedge clk);
            check("timeout_err_clear", 32'(bus.err), 32'h0);
            check("timeout_flush_clear", 32'(bus.unit_flush), 32'h0);
            suppress = 1'b0;
            run_single(2);
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
